// File: rtl/srl_tap_bank.sv
// srl_tap_bank: CHANNELS independent SRL-style shift chains with per-channel enable and runtime read tap.
// Latency: tap read is combinational (same cycle); one extra clock when SRL_TAP_BANK_OUTREG_EN is defined.
// Backpressure: none; en gates shifting, valid qualifies dout through a per-channel fill count.
module srl_tap_bank #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int CHANNELS = 4,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*AW-1:0]    tap,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       valid
);

  localparam int            FW        = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(DEPTH);
  localparam logic [AW:0]   TAP_LIMIT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] TAP_LAST  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] dout_ch  [CHANNELS];
  logic             valid_ch [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] s [DEPTH];
    logic [FW-1:0]    fill;
    logic [AW-1:0]    tap_c;
    logic [AW-1:0]    t_eff;
    logic             v_c;
    logic [WIDTH-1:0] d_c;

    assign tap_c = tap[c*AW +: AW];

    // Shift chain; deliberately reset-free so it maps onto addressable SRL primitives.
    always_ff @(posedge clk) begin
      if (en[c]) begin
        s[0] <= din[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) begin
          s[k] <= s[k-1];
        end
      end
    end

    // Fill count of stages loaded since reset; saturates at DEPTH, reset wins over en.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        fill <= '0;
      end else if (en[c] && (fill != FILL_MAX)) begin
        fill <= fill + FW'(1);
      end
    end

    // Clamp the tap to the last stage, qualify it against fill and mask stale data.
    always_comb begin
      t_eff = ({1'b0, tap_c} >= TAP_LIMIT) ? TAP_LAST : tap_c;
      v_c   = (fill > FW'(t_eff));
      d_c   = v_c ? s[t_eff] : '0;
    end

`ifdef SRL_TAP_BANK_OUTREG_EN
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    // Output register after masking, free-running (not gated by en), cleared with fill.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_c;
        d_q <= d_c;
      end
    end

    assign valid_ch[c] = v_q;
    assign dout_ch[c]  = d_q;
`else
    assign valid_ch[c] = v_c;
    assign dout_ch[c]  = d_c;
`endif
  end

  // Pack per-channel results onto the flat output buses.
  always_comb begin
    dout  = '0;
    valid = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dout[c*WIDTH +: WIDTH] = dout_ch[c];
      valid[c]               = valid_ch[c];
    end
  end

endmodule

// File: tb/tb_srl_tap_bank.sv
// tb_srl_tap_bank: drives a 4-channel DEPTH=32 bank and a 1-channel DEPTH=20 bank as five lanes.
// Latency: expected outputs are queued per cycle and checked mid-cycle by an independent monitor.
// Backpressure: none; every cycle produces one expected record for all lanes.
module tb_srl_tap_bank;

  localparam int NL = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [31:0] din_a;
  logic [3:0]  en_a;
  logic [19:0] tap_a;
  logic [31:0] dout_a;
  logic [3:0]  valid_a;
  logic [7:0]  din_b;
  logic [0:0]  en_b;
  logic [4:0]  tap_b;
  logic [7:0]  dout_b;
  logic [0:0]  valid_b;

  logic [7:0] l_din [NL];
  logic       l_en  [NL];
  logic [4:0] l_tap [NL];

  always_comb begin
    din_a = '0;
    en_a  = '0;
    tap_a = '0;
    for (int c = 0; c < 4; c++) begin
      din_a[c*8 +: 8] = l_din[c];
      en_a[c]         = l_en[c];
      tap_a[c*5 +: 5] = l_tap[c];
    end
    din_b = l_din[4];
    en_b  = l_en[4];
    tap_b = l_tap[4];
  end

  srl_tap_bank #(.WIDTH(8), .DEPTH(32), .CHANNELS(4)) u_a (
    .clk(clk), .rstn(rstn), .din(din_a), .en(en_a), .tap(tap_a), .dout(dout_a), .valid(valid_a)
  );

  srl_tap_bank #(.WIDTH(8), .DEPTH(20), .CHANNELS(1)) u_b (
    .clk(clk), .rstn(rstn), .din(din_b), .en(en_b), .tap(tap_b), .dout(dout_b), .valid(valid_b)
  );

  // Reference model: per-lane history (newest first) and count of samples loaded since reset.
  int         depth_l [NL] = '{32, 32, 32, 32, 20};
  logic [7:0] hist    [NL][$];
  int         fill_m  [NL] = '{0, 0, 0, 0, 0};
  logic       reg_v   [NL] = '{0, 0, 0, 0, 0};
  logic [7:0] reg_d   [NL] = '{0, 0, 0, 0, 0};

  logic [NL-1:0]   q_v   [$];
  logic [NL*8-1:0] q_d   [$];
  string           q_tag [$];

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // One clock: queue what the outputs must show this cycle, then advance the model across the edge.
  task automatic cycle();
    logic [NL-1:0]   cv;
    logic [NL*8-1:0] cd;
    logic [NL-1:0]   ev;
    logic [NL*8-1:0] ed;
    int t;
    for (int l = 0; l < NL; l++) begin
      t = (int'(l_tap[l]) >= depth_l[l]) ? depth_l[l] - 1 : int'(l_tap[l]);
      cv[l] = (fill_m[l] > t);
      cd[l*8 +: 8] = cv[l] ? hist[l][t] : 8'h00;
`ifdef SRL_TAP_BANK_OUTREG_EN
      ev[l] = reg_v[l];
      ed[l*8 +: 8] = reg_d[l];
`else
      ev[l] = cv[l];
      ed[l*8 +: 8] = cd[l*8 +: 8];
`endif
    end
    q_v.push_back(ev);
    q_d.push_back(ed);
    q_tag.push_back(phase);
    @(posedge clk);
    for (int l = 0; l < NL; l++) begin
      reg_v[l] = rstn ? cv[l] : 1'b0;
      reg_d[l] = rstn ? cd[l*8 +: 8] : 8'h00;
      if (!rstn) fill_m[l] = 0;
      else if (l_en[l] && fill_m[l] < depth_l[l]) fill_m[l] = fill_m[l] + 1;
      if (l_en[l]) begin
        hist[l].push_front(l_din[l]);
        if (hist[l].size() > depth_l[l]) void'(hist[l].pop_back());
      end
    end
    #1;
  endtask

  // Monitor: mid-cycle, pop the expected record and compare every lane.
  initial begin
    logic [NL-1:0]   ev, gv;
    logic [NL*8-1:0] ed, gd;
    string tg;
    forever begin
      @(negedge clk);
      if (q_v.size() > 0) begin
        ev = q_v.pop_front();
        ed = q_d.pop_front();
        tg = q_tag.pop_front();
        gv = {valid_b, valid_a};
        gd = {dout_b, dout_a};
        for (int l = 0; l < NL; l++) begin
          n_cmp++;
          if (gv[l] !== ev[l] || gd[l*8 +: 8] !== ed[l*8 +: 8]) begin
            n_bad++;
            $display("FAIL %s lane%0d t=%0t: got valid=%b dout=%h, expected valid=%b dout=%h",
                     tg, l, $time, gv[l], gd[l*8 +: 8], ev[l], ed[l*8 +: 8]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic all_idle();
    for (int l = 0; l < NL; l++) l_en[l] = 1'b0;
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    rstn = 1'b0;
    for (int l = 0; l < NL; l++) begin
      l_din[l] = 8'($urandom);
      l_en[l]  = 1'b1;
      l_tap[l] = 5'($urandom);
    end
    @(posedge clk);
    #1;

    phase = "reset";
    repeat (3) begin
      for (int l = 0; l < NL; l++) l_din[l] = 8'($urandom);
      cycle();
    end
    rstn = 1'b1;
    all_idle();
    cycle();
    cycle();

    phase = "fill_latency";
    l_tap[0] = 5'd5;
    for (int i = 0; i < 40; i++) begin
      l_en[0]  = 1'b1;
      l_din[0] = 8'(i + 1);
      cycle();
    end
    l_en[0] = 1'b0;
    cycle();

    phase = "enable_gaps";
    l_tap[1] = 5'd3;
    for (int i = 0; i < 13; i++) begin
      l_en[1]  = (i < 7) ? pat[i][0] : 1'b1;
      l_din[1] = 8'(32'hA0 + i);
      cycle();
    end
    l_en[1] = 1'b0;

    phase = "tap_sweep";
    for (int i = 0; i < 40; i++) begin
      l_en[2]  = 1'b1;
      l_din[2] = 8'(i);
      cycle();
    end
    l_en[2] = 1'b0;
    for (int tp = 0; tp < 32; tp++) begin
      l_tap[2] = 5'(tp);
      cycle();
    end

    phase = "clamp";
    for (int i = 0; i < 25; i++) begin
      l_en[4]  = 1'b1;
      l_din[4] = 8'(i);
      cycle();
    end
    l_en[4]  = 1'b0;
    l_tap[4] = 5'd31;
    cycle();
    cycle();
    for (int tp = 0; tp < 32; tp++) begin
      l_tap[4] = 5'(tp);
      cycle();
    end

    phase = "random";
    repeat (300) begin
      for (int l = 0; l < NL; l++) begin
        l_en[l]  = 1'($urandom);
        l_din[l] = 8'($urandom);
        l_tap[l] = 5'($urandom);
      end
      cycle();
    end

    phase = "mid_reset";
    for (int i = 0; i < 40; i++) begin
      for (int l = 0; l < NL; l++) begin
        l_en[l]  = 1'b1;
        l_din[l] = 8'($urandom);
        l_tap[l] = 5'($urandom);
      end
      cycle();
    end
    rstn = 1'b0;
    all_idle();
    l_en[3] = 1'b1;
    cycle();
    rstn = 1'b1;
    all_idle();
    cycle();
    l_tap[0] = 5'd7;
    for (int i = 0; i < 12; i++) begin
      l_en[0]  = 1'b1;
      l_din[0] = 8'($urandom);
      for (int l = 1; l < NL; l++) l_tap[l] = 5'($urandom);
      cycle();
    end
    l_en[0] = 1'b0;

    phase = "random_reset";
    repeat (300) begin
      rstn = ($urandom_range(0, 29) != 0);
      for (int l = 0; l < NL; l++) begin
        l_en[l]  = ($urandom_range(0, 3) != 0);
        l_din[l] = 8'($urandom);
        l_tap[l] = 5'($urandom);
      end
      cycle();
    end
    rstn = 1'b1;
    all_idle();
    cycle();

    repeat (3) @(negedge clk);
    if (q_v.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected records left unchecked, required 0", q_v.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/srl_tap_bank.md
# srl_tap_bank

Multi-channel, parametrised shift-register bank with per-channel clock enable and a per-channel dynamic read tap. Each channel maps onto Xilinx SRL primitives (SRL16E/SRLC32E-style addressable shift registers). Fill tracking qualifies outputs, so downstream logic never sees data that was not shifted in since reset. It generalises the fixed-depth, single-bit enable shift chains in the `synth_xilinx_srl` tests to configurable width, depth, channel count and runtime tap selection.

## Interface
- `WIDTH`, 8, data bits per channel
- `DEPTH`, 32, stages per channel (≥2)
- `CHANNELS`, 4, independent channels
- `AW`, `$clog2(DEPTH)`, tap address width
- `clk`  in  1  rising-edge clock, sole clock domain
- `rstn`  in  1  synchronous, active-low reset
- `din`  in  CHANNELS*WIDTH  channel c data at bits [c*WIDTH +: WIDTH]
- `en`  in  CHANNELS  per-channel shift enable
- `tap`  in  CHANNELS*AW  channel c read address at [c*AW +: AW]; 0 = newest stage
- `dout`  out  CHANNELS*WIDTH  selected stage per channel, masked to 0 when not valid
- `valid`  out  CHANNELS  stage at current tap holds data shifted in since reset

One clock; reset is synchronous and active-low.

## Operation
- Per channel c: stage array `s[0..DEPTH-1]`, WIDTH bits each; fill counter `fill`, range 0..DEPTH, width `$clog2(DEPTH+1)`.
- Rising edge with `en[c]=1`: `s[0]<=din_c`, `s[k]<=s[k-1]` for k≥1; `fill<=min(fill+1, DEPTH)`, saturating at DEPTH with no wrap.
- `en[c]=0`: stages and `fill` hold.
- Effective tap `t = (tap_c >= DEPTH) ? DEPTH-1 : tap_c`. This clamp matters only when DEPTH is not a power of two.
- `valid[c] = (fill > t)`; `dout_c = valid[c] ? s[t] : 0`.
- Reset (`rstn=0` at an edge): every `fill<=0`. Stage contents are not cleared, which keeps SRL inference. Because outputs are masked, stale contents are never visible.
- Reset and `en` in the same cycle: reset wins for `fill` (stays 0). Stages may still shift; this is not observable because outputs are masked.
- Reset mid-stream: on the next edge, all `valid` go to 0 and all `dout` go to 0. Refilling restarts from fill=0.
- Channels are fully independent. No cross-channel interaction.

## Timing
- Base build: `dout`/`valid` are combinational from `tap` and registered state.
    - A `tap` change is reflected in the same cycle.
    - A sample captured on enabled edge n appears at tap t after t further enabled edges, i.e. t+1 enabled edges of latency counted from capture.
- Output values after reset: `dout=0`, `valid=0` for all channels, until the first qualifying enabled edge.
- `valid[c]` at tap t first rises immediately after the (t+1)-th enabled edge since reset.
- The `en` low-time between enabled edges does not affect ordering. Latency is counted in enabled edges, not clocks.

## Configuration
- Macro: `SRL_TAP_BANK_OUTREG_EN`.
- Defined:
    - `dout` and `valid` are registered on every clock edge, not gated by `en`, adding exactly one clock of latency to both the data and tap-change paths.
    - Reset clears the output registers to 0 on the same edge that clears `fill`.
    - The register is placed after the masking, so `dout=0` whenever the registered `valid=0`.
- Undefined: combinational outputs as specified above; no extra flops.

## Test plan
- **Reset:** hold `rstn=0` for 3 cycles with `en=all 1` and random `din` -> `valid=0` and `dout=0` on every channel throughout, and on the first edge after release with `en=0`.
- **Fill and latency:** WIDTH=8, DEPTH=32, `tap_0=5`. Enable ch0 each cycle with `din=0x01,0x02,…`.
    - `valid[0]` rises after the 6th edge.
    - `dout_0=0x01`, then 0x02, … on each subsequent edge.
    - Repeat with OUTREG_EN: same sequence, one clock later.
- **Enable gaps:** ch1 `tap=3`; `en[1]` pattern 1,0,0,1,1,0,1 with `din=0xA0+i` -> output order is preserved, and the sample appears only after 4 enabled edges regardless of the idle cycles.
- **Dynamic tap:** ch2 full (40 enabled edges, `din=i`). Sweep `tap_2` over 0..31 with `en=0` -> `dout_2 = 39 - tap` each cycle, same cycle without OUTREG, next cycle with OUTREG.
- **Saturation / clamp:** DEPTH=20. Apply 25 enabled edges, then set `tap=31` -> `fill` is 20, `valid=1`, `dout` equals the stage-19 value (`din` from edge 6).
- **Reset mid-operation and independence:** all channels full; pulse `rstn=0` for one edge with ch3 `en=1`.
    - All `valid` and `dout` are 0 on the next edge.
    - Refill ch0 only -> ch0 becomes valid after tap+1 edges while ch1..3 stay invalid.
    - Compare every channel against a behavioural model on both clock edges.
